// File: rtl/frame_latch_reg.sv
// Frame-synchronous control register: synchronises camera vsync, detects frame
// boundaries and latches d_in only at qualified frame starts.
module frame_latch_reg #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       VSYNC_POL   = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL   = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic [1:0]       mode,
  input  logic             arm,
  output logic [WIDTH-1:0] q,
  output logic             frame_start,
  output logic             frame_end,
  output logic             in_frame,
  output logic             armed,
  output logic             load,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {
    MODE_CONT   = 2'b00,
    MODE_SINGLE = 2'b01
  } mode_e;

  localparam logic             BLANK   = (VSYNC_POL != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   edge_r;
  logic                   qualified;

  logic blank_now;
  logic blank_prev;
  logic start_edge;
  logic end_edge;
  logic fs_ok;
  logic do_load;

  always_comb begin
    blank_now  = (sync_r[SYNC_STAGES-1] == BLANK);
    blank_prev = (edge_r == BLANK);
    start_edge = blank_prev && !blank_now;
    end_edge   = !blank_prev && blank_now;
    fs_ok      = start_edge && qualified;
    do_load    = 1'b0;
    if (fs_ok) begin
      if (mode == MODE_CONT)
        do_load = 1'b1;
      else if (mode == MODE_SINGLE)
        do_load = armed;
    end
  end

  // Chain and edge register preset to blanking so reset never fabricates an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{BLANK}};
      edge_r <= BLANK;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], vsync_in};
      edge_r <= sync_r[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qualified   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      in_frame    <= 1'b0;
      armed       <= 1'b0;
      load        <= 1'b0;
      q           <= RESET_VAL;
      frame_count <= '0;
    end else begin
      frame_start <= fs_ok;
      frame_end   <= end_edge;
      load        <= do_load;
      if (end_edge)
        qualified <= 1'b1;
      if (fs_ok)
        in_frame <= 1'b1;
      else if (end_edge)
        in_frame <= 1'b0;
      if (do_load)
        q <= d_in;
      if (fs_ok)
        frame_count <= frame_count + CNT_ONE;
      // A new arm pulse outranks consumption by a coincident single-shot load.
      if (arm)
        armed <= 1'b1;
      else if (do_load && mode == MODE_SINGLE)
        armed <= 1'b0;
    end
  end

endmodule
